// File: rtl/muldiv_16b.sv
// Multi-cycle unsigned multiply/divide unit writing back through the register-file port.
// Build option: define MULDIV_DIV_EN to include the restoring divider (DIV ops ignored otherwise).
module muldiv_16b #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [REG_AW-1:0] dest,
    output logic              busy,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_reg,
    output logic [WIDTH-1:0]  wb_data,
    output logic              div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start, outputs hold last write-back
    // BUSY  | one shift-add / restore-subtract iteration per cycle
    // WB    | single-cycle write strobe to the register file
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WB} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t            state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]  operand_b;
    logic              hi_sel;
    logic [REG_AW-1:0] dest_q;
    logic [CW-1:0]     count;
    logic              accept;

    // Shared accumulator: MUL keeps {product_hi, multiplier}, DIV keeps {remainder, quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? operand_b : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic               is_div;
    logic               div_zero_op;
    logic               dz_flag;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, operand_b};
        div_ge    = (div_shift >= {1'b0, operand_b});
        if (div_ge)
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        acc_next = is_div ? div_next : mul_next;
    end

    assign accept      = start;
    assign div_by_zero = dz_flag;
`else
    always_comb begin
        acc_next = mul_next;
    end

    assign accept      = start && !op[1];
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            operand_b <= '0;
            hi_sel    <= 1'b0;
            dest_q    <= '0;
            count     <= '0;
            busy      <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
`ifdef MULDIV_DIV_EN
            is_div      <= 1'b0;
            div_zero_op <= 1'b0;
            dz_flag     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    wb_en <= 1'b0;
                    if (accept) begin
                        acc       <= {{WIDTH{1'b0}}, src_a};
                        operand_b <= src_b;
                        hi_sel    <= op[0];
                        dest_q    <= dest;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= ST_BUSY;
`ifdef MULDIV_DIV_EN
                        is_div      <= op[1];
                        div_zero_op <= op[1] && (src_b == '0);
                        dz_flag     <= 1'b0;
`endif
                    end
                end
                ST_BUSY: begin
`ifdef MULDIV_DIV_EN
                    // Divide by zero bypasses the iterations; dividend is still in acc low half.
                    if (div_zero_op) begin
                        state   <= ST_WB;
                        wb_en   <= 1'b1;
                        wb_reg  <= dest_q;
                        wb_data <= hi_sel ? acc[WIDTH-1:0] : {WIDTH{1'b1}};
                        dz_flag <= 1'b1;
                    end else
`endif
                    begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH-1)) begin
                            state   <= ST_WB;
                            wb_en   <= 1'b1;
                            wb_reg  <= dest_q;
                            wb_data <= hi_sel ? acc_next[2*WIDTH-1:WIDTH]
                                              : acc_next[WIDTH-1:0];
                        end
                    end
                end
                ST_WB: begin
                    wb_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    wb_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
